// File: rtl/rs232_recv.sv
// rs232_recv - FT232 serial receiver (8N1, LSB first), companion of rs232_send.
//
// Deserialises the host's transmit line and offers each byte on a valid/ready
// handshake backed by a single holding register. cts_n tells the host to
// pause while that register is full; a frame already in flight is still
// received, and is dropped with an overrun pulse if the register is still
// full when it completes.
//
// Optional feature (compile-time macro):
//   RS232_RECV_PARITY_EN  - an even-parity bit follows bit 7 (11-bit frame);
//                           a parity mismatch raises frame_err and drops the byte.
//   Undefined (default)   - plain 8N1, 10-bit frame.
//
// Parameters:
//   CLOCK_FREQ  system clock in Hz
//   BAUD_RATE   line rate in bit/s
//   Clocks per bit = round(CLOCK_FREQ / BAUD_RATE); must be at least 4.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   rxd        in   serial input, idle high, asynchronous to clock
//   cts_n      out  0 = host may send, 1 = holding register full
//   data       out  received byte, stable while valid is high
//   valid      out  data holds an unconsumed byte
//   ready      in   consumer takes data when valid && ready
//   frame_err  out  one-clock pulse: bad stop bit (or parity)
//   overrun    out  one-clock pulse: byte completed while register full
module rs232_recv #(
    parameter int unsigned CLOCK_FREQ = 133000000,
    parameter int unsigned BAUD_RATE  = 12000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       cts_n,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned BIT  = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned HALF = BIT / 2;
    localparam int unsigned CW   = $clog2(BIT);

    localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RS232_RECV_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
`ifdef RS232_RECV_PARITY_EN
    logic          perr_q, perr_d;
`endif

    logic fire;
    logic deliver;
    logic bad_frame;

    assign fire = (cnt_q == '0);

`ifdef RS232_RECV_PARITY_EN
    assign bad_frame = perr_q;
`else
    assign bad_frame = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitidx_d    = bitidx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef RS232_RECV_PARITY_EN
        perr_d      = perr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rs_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end

            // Re-check the start bit at mid-bit to reject short glitches.
            S_START: begin
                if (fire) begin
                    if (!rs_q) begin
                        state_d  = S_DATA;
                        cnt_d    = BIT_M1;
                        bitidx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            S_DATA: begin
                if (fire) begin
                    shreg_d  = {rs_q, shreg_q[7:1]};
                    bitidx_d = bitidx_q + 3'd1;
                    cnt_d    = BIT_M1;
                    if (bitidx_q == 3'd7) begin
`ifdef RS232_RECV_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

`ifdef RS232_RECV_PARITY_EN
            S_PARITY: begin
                if (fire) begin
                    perr_d  = rs_q ^ (^shreg_q);
                    cnt_d   = BIT_M1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
`endif

            // A low stop bit goes to BREAK so a held-low line cannot
            // immediately re-trigger a start.
            S_STOP: begin
                if (fire) begin
                    if (!rs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end else if (bad_frame) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            S_BREAK: begin
                if (rs_q) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Consumption and a new delivery may coincide; the delivery wins and
        // valid simply stays high with the new byte.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rs_q        <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RS232_RECV_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            sync1_q     <= rxd;
            rs_q        <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef RS232_RECV_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    assign cts_n     = valid_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
